ser_add: RTL and testbench

Bit-serial 8-bit adder. It captures two parallel operands, adds them one bit per clock (LSB first) through a single full adder and a carry flip-flop, and presents the registered parallel sum and carry-out. It is a small arithmetic leaf block used where area matters more than latency. A new addition is started only by pulsing reset.

---
 rtl/ser_add.sv | 106 ++++++++++
 tb/tb_ser_add.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ser_add.sv
`default_nettype none
// ============================================================================
// Module  : ser_add
// Brief   : Bit-serial unsigned adder, one full-adder bit per clock, LSB first.
// Revision: 1.0
// ============================================================================
module ser_add #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ss_q, ss_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             w_s;
   logic             w_carry;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ss_d    = ss_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      w_s     = sa_q[0] ^ sb_q[0] ^ c_q;
      w_carry = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

      case (state_q)
         ST_LOAD: begin
            sa_d    = A;
            sb_d    = B;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = ST_ADD;
         end
         ST_ADD: begin
            c_d   = w_carry;
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            // New bit enters at the MSB so the first computed bit lands at the LSB.
            ss_d  = WIDTH'({w_s, ss_q} >> 1);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               sum_d   = WIDTH'({w_s, ss_q} >> 1);
               cout_d  = w_carry;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_LOAD;
         sa_q    <= '0;
         sb_q    <= '0;
         ss_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ss_q    <= ss_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign Sum  = sum_q;
   assign Cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_add.sv
`default_nettype none
// ============================================================================
// Module  : tb_ser_add
// Brief   : Scoreboard bench for the bit-serial adder.
// Revision: 1.0
// ============================================================================
module tb_ser_add;

   logic       clk;
   logic       reset;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] Sum;
   logic       Cout;

   int         checks;
   int         errors;
   logic [8:0] exp_q[$];
   logic [8:0] last_exp;

   ser_add #(.WIDTH(8)) dut (
      .clk  (clk),
      .reset(reset),
      .A    (A),
      .B    (B),
      .Sum  (Sum),
      .Cout (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reset, load a/b, then watch all nine edges; the result is only allowed on the last.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit change_mid);
      logic [8:0] e;
      @(negedge clk);
      reset = 1'b0;
      A     = a;
      B     = b;
      #1 check_val("in_reset", {Cout, Sum}, 9'h000);
      @(negedge clk);
      reset = 1'b1;
      exp_q.push_back({1'b0, a} + {1'b0, b});
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (change_mid && k == 1) begin
            A = 8'hFF;
            B = 8'hFF;
         end
         if (k < 9) begin
            check_val("pre_done", {Cout, Sum}, 9'h000);
         end else if (exp_q.size() == 0) begin
            check_val("sb_empty", 9'(exp_q.size()), 9'h001);
         end else begin
            e        = exp_q.pop_front();
            last_exp = e;
            check_val("result", {Cout, Sum}, e);
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_exp = '0;
      reset    = 1'b0;
      A        = 8'h2A;
      B        = 8'h2A;
      #20;
      check_val("por_reset", {Cout, Sum}, 9'h000);

      run_op(8'h3A, 8'h3A, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b0);

      // Asynchronous clear of a finished result, well away from any edge.
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check_val("async_clr", {Cout, Sum}, 9'h000);

      run_op(8'h00, 8'h00, 1'b0);
      run_op(8'h0F, 8'h01, 1'b1);

      // Abort mid-ADD at the 4th add edge, then a fresh addition.
      @(negedge clk);
      reset = 1'b0;
      A     = 8'h80;
      B     = 8'h80;
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1 check_val("abort", {Cout, Sum}, 9'h000);
      run_op(8'h01, 8'h02, 1'b0);

      // Result must hold while the operands wander.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("hold", {Cout, Sum}, last_exp);
         A = 8'($urandom);
         B = 8'($urandom);
      end

      for (int i = 0; i < 6; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
